// File: rtl/popcount_frame_pkg.sv
// Shared types and constants for the popcount frame controller.
package popcount_frame_pkg;

   // Frame controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Largest value the accumulator may hold; larger sums saturate here
   localparam logic [3:0] ACC_MAX = 4'd15;

   // Width of the beat counter
   localparam int BEAT_W = 4;

   // Active-high 7-segment font, bit0=a .. bit6=g, entry 15 first
   localparam logic [15:0][6:0] SEG_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/popcount_frame_ctrl_seg7.sv
// Purely combinational hex digit to 7-segment decoder.
module seg7_hex_decoder
   import popcount_frame_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   // Table lookup into the shared hex font
   always_comb begin
      seg = SEG_FONT[hex];
   end

endmodule

// File: rtl/popcount_frame_ctrl.sv
// Counts the ones in a fixed number of valid data nibbles per frame,
// saturating at 15, and shows the running total on a 7-segment digit.
module popcount_frame_ctrl
   import popcount_frame_pkg::*;
#(
   parameter int FRAME_BEATS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       valid,
   input  logic [3:0] data,
   output logic [6:0] seg,
   output logic       dp
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};

   // Number of set bits in a nibble (0..4)
   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   state_e              state_r;
   state_e              state_nxt_s;
   logic [3:0]          acc_r;
   logic [3:0]          acc_nxt_s;
   logic [BEAT_W-1:0]   beats_r;
   logic [BEAT_W-1:0]   beats_nxt_s;
   logic                sat_r;
   logic                sat_nxt_s;
   logic                dp_r;
   logic                dp_nxt_s;
   logic [4:0]          sum_s;
   logic [BEAT_W-1:0]   beats_inc_s;

   // True (unsaturated) sum and next beat index for the current beat
   always_comb begin
      sum_s       = {1'b0, acc_r} + {2'b00, popcount4(data)};
      beats_inc_s = beats_r + BEAT_ONE;
   end

   // Next-state logic: start wins over valid everywhere and restarts the frame
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      beats_nxt_s = beats_r;
      sat_nxt_s   = sat_r;
      case (state_r)
         ST_IDLE, ST_HOLD: begin
            if (start) begin
               state_nxt_s = ST_ACCUM;
               acc_nxt_s   = 4'd0;
               beats_nxt_s = {BEAT_W{1'b0}};
               sat_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_ACCUM: begin
            if (start) begin
               acc_nxt_s   = 4'd0;
               beats_nxt_s = {BEAT_W{1'b0}};
               sat_nxt_s   = 1'b0;
            end else if (valid) begin
               if (sum_s > {1'b0, ACC_MAX}) begin
                  acc_nxt_s = ACC_MAX;
                  sat_nxt_s = 1'b1;
               end else begin
                  acc_nxt_s = sum_s[3:0];
               end
               beats_nxt_s = beats_inc_s;
               if (beats_inc_s == LAST_BEAT) begin
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_ACCUM;
               end
            end else begin
               state_nxt_s = ST_ACCUM;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            acc_nxt_s   = 4'd0;
            beats_nxt_s = {BEAT_W{1'b0}};
            sat_nxt_s   = 1'b0;
         end
      endcase
   end

   // Status indicator for the next cycle: busy in ACCUM, saturation flag in HOLD
   always_comb begin
      case (state_nxt_s)
         ST_IDLE:  dp_nxt_s = 1'b0;
         ST_ACCUM: dp_nxt_s = 1'b1;
         ST_HOLD:  dp_nxt_s = sat_nxt_s;
         default:  dp_nxt_s = 1'b0;
      endcase
   end

   // State, accumulator, beat counter, saturation flag and dp registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         acc_r   <= 4'd0;
         beats_r <= {BEAT_W{1'b0}};
         sat_r   <= 1'b0;
         dp_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         acc_r   <= acc_nxt_s;
         beats_r <= beats_nxt_s;
         sat_r   <= sat_nxt_s;
         dp_r    <= dp_nxt_s;
      end
   end

   assign dp = dp_r;

   seg7_hex_decoder u_seg7 (
      .hex (acc_r),
      .seg (seg)
   );

endmodule

// File: tb/tb_popcount_frame_ctrl.sv
// Self-checking bench: a FRAME_BEATS=4 and a FRAME_BEATS=5 instance share
// stimulus and are compared against a frame-level model (running true sum).
module tb_popcount_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       valid = 1'b0;
   logic [3:0] data = 4'd0;
   logic [6:0] seg4, seg5;
   logic       dp4, dp5;
   logic [6:0] segs [2];
   logic       dps [2];

   int n_cmp = 0;
   int n_fail = 0;

   // Model: phase 0 = idle, 1 = collecting, 2 = frame done
   int m_phase [2];
   int m_sum   [2];
   int m_beats [2];
   int fbeats  [2] = '{4, 5};
   logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   popcount_frame_ctrl #(.FRAME_BEATS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .data(data),
      .seg(seg4), .dp(dp4));

   popcount_frame_ctrl #(.FRAME_BEATS(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .data(data),
      .seg(seg5), .dp(dp5));

   always #5 clk = ~clk;

   always_comb begin
      segs[0] = seg4; segs[1] = seg5;
      dps[0]  = dp4;  dps[1]  = dp5;
   end

   function automatic logic [6:0] m_seg(int k);
      return font[(m_sum[k] > 15) ? 15 : m_sum[k]];
   endfunction

   function automatic logic m_dp(int k);
      if (m_phase[k] == 0) return 1'b0;
      if (m_phase[k] == 1) return 1'b1;
      return (m_sum[k] > 15);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_phase[k] = 0; m_sum[k] = 0; m_beats[k] = 0;
      end
   endtask

   // Apply one cycle of inputs, advance the model at the edge, settle #1 after it
   task automatic drive(input logic s, input logic v, input logic [3:0] d);
      start = s; valid = v; data = d;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (s) begin
            m_phase[k] = 1; m_sum[k] = 0; m_beats[k] = 0;
         end else if (v && m_phase[k] == 1) begin
            m_sum[k] += $countones(d);
            m_beats[k]++;
            if (m_beats[k] == fbeats[k]) m_phase[k] = 2;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      #3;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (segs[k] !== 7'h3F || dps[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init[%0d] seg=%h dp=%b want seg=3F dp=0", k, segs[k], dps[k]);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 4'hF);
      n_cmp++;
      if (seg4 !== 7'h3F || dp4 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle seg=%h dp=%b want seg=3F dp=0", seg4, dp4);
      end
      drive(1'b1, 1'b0, 4'h0);
      n_cmp++;
      if (dp4 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_edge dp=%b want 1", dp4);
      end
      drive(1'b0, 1'b1, 4'b0111);
      drive(1'b0, 1'b1, 4'b1111);
      n_cmp++;
      if (seg4 !== 7'h07) begin
         n_fail++;
         $display("FAIL reset_acc7 seg=%h want 07", seg4);
      end
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (segs[k] !== 7'h3F || dps[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async[%0d] seg=%h dp=%b want seg=3F dp=0", k, segs[k], dps[k]);
         end
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_normal_frame();
      logic [3:0] d [4]   = '{4'b0001, 4'b0011, 4'b0111, 4'b0000};
      logic [6:0] es [4]  = '{7'h06, 7'h4F, 7'h7D, 7'h7D};
      logic       ed [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      drive(1'b1, 1'b0, 4'h0);
      n_cmp++;
      if (seg4 !== 7'h3F || dp4 !== 1'b1) begin
         n_fail++;
         $display("FAIL normal_start seg=%h dp=%b want seg=3F dp=1", seg4, dp4);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, d[i]);
         n_cmp++;
         if (seg4 !== es[i] || dp4 !== ed[i]) begin
            n_fail++;
            $display("FAIL normal_beat%0d seg=%h dp=%b want seg=%h dp=%b", i, seg4, dp4, es[i], ed[i]);
         end
         n_cmp++;
         if (seg5 !== m_seg(1) || dp5 !== m_dp(1)) begin
            n_fail++;
            $display("FAIL normal5_beat%0d seg=%h dp=%b want seg=%h dp=%b", i, seg5, dp5, m_seg(1), m_dp(1));
         end
      end
   endtask

   task automatic test_saturation();
      logic [6:0] es [4] = '{7'h66, 7'h7F, 7'h39, 7'h71};
      drive(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 4'hF);
         n_cmp++;
         if (seg4 !== es[i]) begin
            n_fail++;
            $display("FAIL sat_beat%0d seg=%h want %h", i, seg4, es[i]);
         end
      end
      n_cmp++;
      if (dp4 !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_hold_dp dp=%b want 1", dp4);
      end
      drive(1'b0, 1'b1, 4'hF);
      n_cmp++;
      if (seg5 !== 7'h71 || dp5 !== 1'b1 || seg4 !== 7'h71) begin
         n_fail++;
         $display("FAIL sat_fifth seg5=%h dp5=%b seg4=%h want 71 1 71", seg5, dp5, seg4);
      end
   endtask

   task automatic test_gapped();
      logic [3:0] d [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b0000};
      drive(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < 3; g++) begin
            drive(1'b0, 1'b0, 4'hF);
            n_cmp++;
            if (dp4 !== 1'b1 || seg4 !== m_seg(0)) begin
               n_fail++;
               $display("FAIL gap_b%0d_g%0d seg=%h dp=%b want seg=%h dp=1", i, g, seg4, dp4, m_seg(0));
            end
         end
         drive(1'b0, 1'b1, d[i]);
      end
      n_cmp++;
      if (seg4 !== 7'h7D || dp4 !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_result seg=%h dp=%b want seg=7D dp=0", seg4, dp4);
      end
   endtask

   task automatic test_start_valid();
      drive(1'b1, 1'b0, 4'h0);
      drive(1'b0, 1'b1, 4'b0111);
      drive(1'b0, 1'b1, 4'b0011);
      n_cmp++;
      if (seg4 !== 7'h6D) begin
         n_fail++;
         $display("FAIL sv_acc5 seg=%h want 6D", seg4);
      end
      drive(1'b1, 1'b1, 4'hF);
      n_cmp++;
      if (seg4 !== 7'h3F || dp4 !== 1'b1) begin
         n_fail++;
         $display("FAIL sv_restart seg=%h dp=%b want seg=3F dp=1", seg4, dp4);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 4'b0001);
         n_cmp++;
         if (dp4 !== ((i < 3) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL sv_beatcount%0d dp=%b want %b", i, dp4, (i < 3));
         end
      end
   endtask

   task automatic test_ignored();
      drive(1'b0, 1'b1, 4'hF);
      n_cmp++;
      if (seg4 !== 7'h66 || dp4 !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_hold seg=%h dp=%b want seg=66 dp=0", seg4, dp4);
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      #1 rst_n = 1'b1;
      drive(1'b0, 1'b1, 4'hF);
      drive(1'b0, 1'b1, 4'hF);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (segs[k] !== 7'h3F || dps[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_idle[%0d] seg=%h dp=%b want seg=3F dp=0", k, segs[k], dps[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            for (int k = 0; k < 2; k++) begin
               n_cmp++;
               if (segs[k] !== 7'h3F || dps[k] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL rand_reset%0d[%0d] seg=%h dp=%b", i, k, segs[k], dps[k]);
               end
            end
            #1 rst_n = 1'b1;
         end
         drive(($urandom_range(0, 11) == 0), $urandom_range(0, 1) == 1,
               4'($urandom_range(0, 15)));
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (segs[k] !== m_seg(k) || dps[k] !== m_dp(k)) begin
               n_fail++;
               $display("FAIL rand%0d[%0d] seg=%h dp=%b want seg=%h dp=%b",
                        i, k, segs[k], dps[k], m_seg(k), m_dp(k));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal_frame();
      test_saturation();
      test_gapped();
      test_start_valid();
      test_ignored();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/popcount_frame_ctrl.md
POPCOUNT_FRAME_CTRL -- requirements
Module: popcount_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_BEATS, default 4, number of valid beats per frame (legal 1..15).
REQ-002 The block SHALL have port io_in[0]  input  1  clk, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port io_in[1]  input  1  rst_n, reset, asynchronous, active-low.
REQ-004 The block SHALL have port io_in[2]  input  1  start, which begins a new frame.
REQ-005 The block SHALL have port io_in[3]  input  1  valid, which qualifies the data nibble this cycle.
REQ-006 The block SHALL have port io_in[7:4]  input  4  data, the bits whose ones are counted.
REQ-007 The block SHALL have port io_out[6:0]  output  7  seg, active-high 7-segment, bit0=a through bit6=g.
REQ-008 The block SHALL have port io_out[7]  output  1  dp, the status indicator.

Function
REQ-009 The block SHALL implement states IDLE, ACCUM and HOLD.
REQ-010 IDLE with start=1 SHALL go to ACCUM, clear acc to 0, clear beat count, and clear sat.
REQ-011 ACCUM with valid=1 and start=0 SHALL add popcount(data) (0..4) to acc and increment beat count.
REQ-012 Accumulation SHALL saturate acc at 15 and SHALL set sat when the true sum exceeds 15.
REQ-013 The valid beat that makes beat count equal FRAME_BEATS SHALL be accumulated, and the FSM SHALL enter HOLD on that edge.
REQ-014 ACCUM with valid=0 SHALL hold all state, with no timeout.
REQ-015 HOLD SHALL freeze acc and sat, and start=1 SHALL restart as in REQ-010.
REQ-016 start=1 in any state SHALL take priority over valid, and the same-cycle valid beat SHALL be discarded.
REQ-017 start=1 in ACCUM SHALL abort the frame and restart it (acc=0, beats=0, sat=0).
REQ-018 valid in IDLE or HOLD SHALL be ignored.
REQ-019 seg SHALL be a combinational hex decode of the acc register: 0x0->7'h3F, 0x4->7'h66, 0x8->7'h7F, 0xC->7'h39, 0xF->7'h71, standard hex font.
REQ-020 Latency: a beat sampled at edge N SHALL be visible on seg after edge N, and no output path from io_in to io_out SHALL exist.
REQ-021 dp SHALL be 0 in IDLE, 1 in ACCUM (busy), and equal sat in HOLD.
REQ-022 The beat counter SHALL be 4 bits and SHALL never wrap, because the FSM leaves ACCUM at FRAME_BEATS.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, acc=0, beats=0 and sat=0, so that seg=7'h3F and dp=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no residual state.
REQ-025 After rst_n rises, the first edge SHALL be evaluated normally.

Structure
REQ-026 Package popcount_frame_pkg SHALL hold the state enum, ACC_MAX=15, the beat-counter width and the 16-entry segment font table.
REQ-027 The block SHALL have one sub-module, seg7_hex_decoder: 4-bit in, 7-bit out, purely combinational.
REQ-028 Popcount, FSM, accumulator and counter SHALL stay in popcount_frame_ctrl.

Verification
REQ-029 Reset check: pulse rst_n low mid-ACCUM with acc=7 -> seg=7'h3F and dp=0 immediately, without waiting for a clock edge.
REQ-030 Normal frame: start; valid beats data=4'b0001, 4'b0011, 4'b0111, 4'b0000 -> seg shows 1, 3, 6, 6, then HOLD with seg=7'h7D (6) and dp=0.
REQ-031 Saturation: start; 4 beats of data=4'hF -> acc=15, seg=7'h71 (F) and dp=1 in HOLD; with FRAME_BEATS=5, a fifth 4'hF beat keeps 15.
REQ-032 Gapped valid: start; beats with valid=0 gaps of 3 cycles between them -> the same result as back-to-back, and dp stays 1 throughout ACCUM.
REQ-033 Simultaneous start and valid: in ACCUM with acc=5, start=1 and valid=1 with data=4'hF -> acc=0, beats=0, state ACCUM.
REQ-034 Ignored input: valid=1 with data=4'hF in IDLE and in HOLD -> seg and dp unchanged.
